// File: rtl/light_monitor_if.sv
// Lamp-code inputs and tracked-phase / fault status of the traffic light monitor.
// The master drives the lamps and observes status; the slave is the monitor.
interface light_monitor_if;
    logic [2:0]  light_highway;
    logic [2:0]  light_farm;
    logic [1:0]  phase;
    logic        phase_valid;
    logic        fault;
    logic [2:0]  fault_code;
    logic        cycle_done;
    logic [15:0] cycle_count;

    modport master (
        output light_highway,
        output light_farm,
        input  phase,
        input  phase_valid,
        input  fault,
        input  fault_code,
        input  cycle_done,
        input  cycle_count
    );

    modport slave (
        input  light_highway,
        input  light_farm,
        output phase,
        output phase_valid,
        output fault,
        output fault_code,
        output cycle_done,
        output cycle_count
    );
endinterface

// File: rtl/light_monitor.sv
// Passive protocol checker for a highway/farm traffic light controller: tracks the
// phase sequence, enforces minimum yellow and farm-green dwell, latches the first fault.
module light_monitor #(
    parameter int unsigned YEL_MIN_CYC  = 150000000,
    parameter int unsigned FGRN_MIN_CYC = 500000000
) (
    input logic             clk,
    input logic             rst,
    light_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        FAULT
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_ILLEGAL    = 3'd1,
        FC_SKIP       = 3'd2,
        FC_SHORT_YEL  = 3'd3,
        FC_SHORT_FGRN = 3'd4
    } fault_code_e;

    state_e      state, state_nxt;
    logic [1:0]  phase, phase_nxt;
    logic        phase_valid, phase_valid_nxt;
    logic        fault, fault_nxt;
    fault_code_e fault_code, fault_code_nxt;
    logic        cycle_done, cycle_done_nxt;
    logic [15:0] cycle_count, cycle_count_nxt;
    logic [31:0] dwell, dwell_nxt;
    logic        exempt, exempt_nxt;

    logic        pair_legal;
    logic [1:0]  pair_phase;
    logic [1:0]  phase_inc;
    logic        dwell_short;

    // Only the four one-hot combinations the controller may show are legal.
    always_comb begin
        pair_legal = 1'b1;
        pair_phase = 2'd0;
        case ({bus.light_highway, bus.light_farm})
            6'b001_100: pair_phase = 2'd0;
            6'b010_100: pair_phase = 2'd1;
            6'b100_001: pair_phase = 2'd2;
            6'b100_010: pair_phase = 2'd3;
            default:    pair_legal = 1'b0;
        endcase
    end

    assign phase_inc = phase + 2'd1;

    // Outgoing-dwell check; phase 0 has no minimum and the first phase seen is exempt.
    always_comb begin
        dwell_short = 1'b0;
        case (phase)
            2'd1, 2'd3: dwell_short = (dwell < YEL_MIN_CYC);
            2'd2:       dwell_short = (dwell < FGRN_MIN_CYC);
            default:    dwell_short = 1'b0;
        endcase
        if (exempt) dwell_short = 1'b0;
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        fault_nxt       = fault;
        fault_code_nxt  = fault_code;
        cycle_done_nxt  = 1'b0;
        cycle_count_nxt = cycle_count;
        dwell_nxt       = dwell;
        exempt_nxt      = exempt;

        case (state)
            SYNC: begin
                if (!pair_legal) begin
                    state_nxt      = FAULT;
                    fault_nxt      = 1'b1;
                    fault_code_nxt = FC_ILLEGAL;
                end else begin
                    state_nxt  = TRACK;
                    phase_nxt  = pair_phase;
                    dwell_nxt  = 32'd1;
                    exempt_nxt = 1'b1;
                end
            end

            TRACK: begin
                if (!pair_legal) begin
                    state_nxt      = FAULT;
                    fault_nxt      = 1'b1;
                    fault_code_nxt = FC_ILLEGAL;
                end else if (pair_phase == phase) begin
                    if (dwell != '1) dwell_nxt = dwell + 32'd1;
                end else if (pair_phase == phase_inc) begin
                    if (dwell_short) begin
                        state_nxt      = FAULT;
                        fault_nxt      = 1'b1;
                        fault_code_nxt = (phase == 2'd2) ? FC_SHORT_FGRN : FC_SHORT_YEL;
                    end else begin
                        phase_nxt  = pair_phase;
                        dwell_nxt  = 32'd1;
                        exempt_nxt = 1'b0;
                        if (phase == 2'd3) begin
                            cycle_done_nxt  = 1'b1;
                            cycle_count_nxt = cycle_count + 16'd1;
                        end
                    end
                end else begin
                    state_nxt      = FAULT;
                    fault_nxt      = 1'b1;
                    fault_code_nxt = FC_SKIP;
                end
            end

            FAULT: begin
                state_nxt = FAULT;
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase

        phase_valid_nxt = (state_nxt == TRACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            phase       <= 2'd0;
            phase_valid <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            dwell       <= '0;
            exempt      <= 1'b1;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            phase_valid <= phase_valid_nxt;
            fault       <= fault_nxt;
            fault_code  <= fault_code_nxt;
            cycle_done  <= cycle_done_nxt;
            cycle_count <= cycle_count_nxt;
            dwell       <= dwell_nxt;
            exempt      <= exempt_nxt;
        end
    end

    assign bus.phase       = phase;
    assign bus.phase_valid = phase_valid;
    assign bus.fault       = fault;
    assign bus.fault_code  = fault_code;
    assign bus.cycle_done  = cycle_done;
    assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor with short dwell limits (yellow 3, farm green 10).
module tb_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned done_pulses;

    light_monitor_if bus ();

    light_monitor #(
        .YEL_MIN_CYC  (3),
        .FGRN_MIN_CYC (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply one lamp pair for one clock; outputs reflect that sample on return.
    task automatic step(input logic [2:0] h, input logic [2:0] f);
        @(negedge clk);
        bus.light_highway = h;
        bus.light_farm    = f;
        @(posedge clk);
        #1;
        if (bus.cycle_done === 1'b1) done_pulses++;
    endtask

    task automatic steps(input logic [2:0] h, input logic [2:0] f, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(h, f);
    endtask

    task automatic do_reset(input logic [2:0] h, input logic [2:0] f);
        rst = 1'b1;
        step(h, f);
        rst = 1'b0;
        done_pulses = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"},  32'(bus.phase), 32'd0);
        check({tag, "_valid"},  32'(bus.phase_valid), 32'd0);
        check({tag, "_fault"},  32'(bus.fault), 32'd0);
        check({tag, "_code"},   32'(bus.fault_code), 32'd0);
        check({tag, "_done"},   32'(bus.cycle_done), 32'd0);
        check({tag, "_count"},  32'(bus.cycle_count), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_pulses = 0;
        rst = 1'b1;
        bus.light_highway = G;
        bus.light_farm    = R;

        // Reset state, with an illegal pair present during reset
        do_reset(G, G);
        check_reset_outputs("rst");

        // Full legal cycle
        step(G, R);
        check("sync_valid", 32'(bus.phase_valid), 32'd1);
        check("sync_phase", 32'(bus.phase), 32'd0);
        steps(G, R, 4);
        steps(Y, R, 3);
        check("hy_phase", 32'(bus.phase), 32'd1);
        steps(R, G, 10);
        check("fg_phase", 32'(bus.phase), 32'd2);
        steps(R, Y, 3);
        check("fy_phase", 32'(bus.phase), 32'd3);
        check("pre_done", 32'(bus.cycle_done), 32'd0);
        step(G, R);
        check("cyc_done", 32'(bus.cycle_done), 32'd1);
        check("cyc_count", 32'(bus.cycle_count), 32'd1);
        check("cyc_fault", 32'(bus.fault), 32'd0);
        check("cyc_phase", 32'(bus.phase), 32'd0);
        step(G, R);
        check("done_drop", 32'(bus.cycle_done), 32'd0);
        check("done_pulses", done_pulses, 32'd1);

        // Short yellow after a completed cycle
        steps(Y, R, 2);
        step(R, G);
        check("syel_fault", 32'(bus.fault), 32'd1);
        check("syel_code", 32'(bus.fault_code), 32'd3);
        check("syel_phase", 32'(bus.phase), 32'd1);
        check("syel_valid", 32'(bus.phase_valid), 32'd0);
        steps(R, G, 2);
        check("syel_hold_code", 32'(bus.fault_code), 32'd3);
        check("syel_hold_count", 32'(bus.cycle_count), 32'd1);

        // Illegal pair in TRACK, then legal pairs: fault holds
        do_reset(G, R);
        steps(G, R, 2);
        step(G, G);
        check("ill_fault", 32'(bus.fault), 32'd1);
        check("ill_code", 32'(bus.fault_code), 32'd1);
        check("ill_valid", 32'(bus.phase_valid), 32'd0);
        steps(G, R, 2);
        steps(Y, R, 1);
        check("ill_hold_fault", 32'(bus.fault), 32'd1);
        check("ill_hold_code", 32'(bus.fault_code), 32'd1);
        check("ill_hold_done", 32'(bus.cycle_done), 32'd0);

        // Non-one-hot code in SYNC
        do_reset(G, R);
        step(3'b011, R);
        check("nonhot_code", 32'(bus.fault_code), 32'd1);
        check("nonhot_valid", 32'(bus.phase_valid), 32'd0);

        // Sequence skip 0 -> 2
        do_reset(G, R);
        steps(G, R, 2);
        step(R, G);
        check("skip_code", 32'(bus.fault_code), 32'd2);
        check("skip_phase", 32'(bus.phase), 32'd0);

        // Reset during fault, then re-entry into TRACK
        do_reset(G, R);
        check_reset_outputs("rstf");
        step(G, R);
        check("rstf_valid", 32'(bus.phase_valid), 32'd1);
        check("rstf_fault", 32'(bus.fault), 32'd0);

        // Backward step 1 -> 0 is a skip
        steps(Y, R, 3);
        step(G, R);
        check("back_code", 32'(bus.fault_code), 32'd2);
        check("back_phase", 32'(bus.phase), 32'd1);

        // Mid-cycle sync: exempt short farm yellow
        do_reset(G, R);
        step(R, Y);
        check("mid_phase", 32'(bus.phase), 32'd3);
        check("mid_valid", 32'(bus.phase_valid), 32'd1);
        step(G, R);
        check("mid_fault", 32'(bus.fault), 32'd0);
        check("mid_done", 32'(bus.cycle_done), 32'd1);
        check("mid_count", 32'(bus.cycle_count), 32'd1);
        step(G, R);
        check("mid_pulses", done_pulses, 32'd1);

        // Short farm green (5 < 10)
        do_reset(G, R);
        step(G, R);
        steps(Y, R, 3);
        steps(R, G, 5);
        step(R, Y);
        check("sfg_code", 32'(bus.fault_code), 32'd4);
        check("sfg_phase", 32'(bus.phase), 32'd2);

        // Farm green exactly at the limit then short farm yellow (2 < 3)
        do_reset(G, R);
        step(G, R);
        steps(Y, R, 3);
        steps(R, G, 10);
        steps(R, Y, 2);
        check("fy_ok_fault", 32'(bus.fault), 32'd0);
        step(G, R);
        check("sfy_code", 32'(bus.fault_code), 32'd3);
        check("sfy_phase", 32'(bus.phase), 32'd3);
        check("sfy_count", 32'(bus.cycle_count), 32'd0);
        check("sfy_done", 32'(bus.cycle_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
